// File: rtl/fetdriver_ls_seq_pkg.sv
// Shared types and constants for the FET-driver logic-shifter sequencer.
package fetdriver_ls_seq_pkg;

  localparam int unsigned LS_W     = 2;
  localparam int unsigned LS_TOPSW = 0;
  localparam int unsigned LS_ROFF  = 1;

  typedef enum logic [2:0] {
    OFF,
    WAKE,
    IDLE,
    SOFT,
    FULL,
    DRAIN,
    DEAD,
    FAULT
  } ls_state_e;

endpackage

// File: rtl/fetdriver_ls_seq_timer.sv
// Loadable down-counter that parks at zero; zero flag is registered with the count.
module fetdriver_ls_seq_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count;
    if (load) begin
      count_d = value;
    end else if (!zero) begin
      count_d = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
      zero  <= 1'b1;
    end else begin
      count <= count_d;
      zero  <= (count_d == '0);
    end
  end

endmodule

// File: rtl/fetdriver_ls_sequencer.sv
// Wakes the low-to-high logic shifter and stages PWM requests into
// top-switch / Roff-adjust commands with Roff delay, dead-time and sticky fault.
module fetdriver_ls_sequencer
  import fetdriver_ls_seq_pkg::*;
#(
  parameter int unsigned WAKE_CYCLES = 16,
  parameter int unsigned ROFF_DELAY  = 4,
  parameter int unsigned DEADTIME    = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            drv_enable,
  input  logic            pwm_req,
  input  logic            fault,
  output logic [LS_W-1:0] ls_in,
  output logic            ls_enable,
  output logic            ready,
  output logic            fault_latched
);

  localparam logic [63:0] CNT_SPAN = 64'd1 << CNT_W;

  if (WAKE_CYCLES == 0 || 64'(WAKE_CYCLES) > CNT_SPAN) begin : g_bad_wake
    $error("WAKE_CYCLES out of range");
  end
  if (ROFF_DELAY == 0 || 64'(ROFF_DELAY) > CNT_SPAN) begin : g_bad_roff
    $error("ROFF_DELAY out of range");
  end
  if (DEADTIME == 0 || 64'(DEADTIME) > CNT_SPAN) begin : g_bad_dead
    $error("DEADTIME out of range");
  end

  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ROFF_LD = CNT_W'(ROFF_DELAY - 1);
  localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'(DEADTIME - 1);

  ls_state_e        state;
  ls_state_e        state_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_zero;
  logic [LS_W-1:0]  ls_in_d;
  logic             ls_enable_d;
  logic             ready_d;
  logic             fault_latched_d;

  fetdriver_ls_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .load   (tmr_load),
    .value  (tmr_value),
    .zero   (tmr_zero)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= OFF;
    end else begin
      state <= state_d;
    end
  end

  // Next state and timer loads; enable drop beats fault, fault beats normal flow.
  always_comb begin
    state_d   = state;
    tmr_load  = 1'b0;
    tmr_value = '0;
    if (!drv_enable) begin
      state_d = OFF;
    end else if (fault && state != OFF) begin
      state_d = FAULT;
    end else begin
      unique case (state)
        OFF: begin
          state_d   = WAKE;
          tmr_load  = 1'b1;
          tmr_value = WAKE_LD;
        end
        WAKE: if (tmr_zero) state_d = IDLE;
        IDLE: begin
          if (pwm_req) begin
            state_d   = SOFT;
            tmr_load  = 1'b1;
            tmr_value = ROFF_LD;
          end
        end
        SOFT: begin
          if (!pwm_req) begin
            state_d   = DEAD;
            tmr_load  = 1'b1;
            tmr_value = DEAD_LD;
          end else if (tmr_zero) begin
            state_d = FULL;
          end
        end
        FULL: begin
          if (!pwm_req) begin
            state_d   = DRAIN;
            tmr_load  = 1'b1;
            tmr_value = ROFF_LD;
          end
        end
        DRAIN: begin
          if (tmr_zero) begin
            state_d   = DEAD;
            tmr_load  = 1'b1;
            tmr_value = DEAD_LD;
          end
        end
        DEAD:    if (tmr_zero) state_d = IDLE;
        FAULT:   state_d = FAULT;
        default: state_d = OFF;
      endcase
    end
  end

  // Outputs decoded from the next state so the flops present them one edge later.
  always_comb begin
    ls_in_d         = '0;
    ls_enable_d     = (state_d != OFF);
    ready_d         = (state_d == IDLE);
    fault_latched_d = (state_d == FAULT);
    case (state_d)
      SOFT, DRAIN: ls_in_d[LS_TOPSW] = 1'b1;
      FULL: begin
        ls_in_d[LS_TOPSW] = 1'b1;
        ls_in_d[LS_ROFF]  = 1'b1;
      end
      default: ls_in_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ls_in         <= '0;
      ls_enable     <= 1'b0;
      ready         <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      ls_in         <= ls_in_d;
      ls_enable     <= ls_enable_d;
      ready         <= ready_d;
      fault_latched <= fault_latched_d;
    end
  end

endmodule
